// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared MDU cycle counts, unused-operand marker and MDU state encoding
package pipe_ctrl_pkg;
   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;
   localparam logic [1:0] TUSE_NONE   = 2'd3;
   typedef enum logic {MDU_IDLE = 1'b0, MDU_BUSY = 1'b1} mdu_state_e;
endpackage

// File: rtl/mdu_busy_cnt.sv
// mdu_busy_cnt: tracks multiply/divide occupancy with a down-counter so D-stage MDU ops can wait
module mdu_busy_cnt
   import pipe_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic is_div_i,
   input  logic req_i,
   output logic busy_o
);
   mdu_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   // state and counter registers; reset overrides any start or flush
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // a flushed start never launches; a running operation ignores new starts and flushes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == MDU_BUSY) begin
         state_d = (cnt_q > 4'd1) ? MDU_BUSY : MDU_IDLE;
         cnt_d   = (cnt_q > 4'd1) ? cnt_q - 4'd1 : 4'd0;
      end else if (start_i && !req_i) begin
         state_d = MDU_BUSY;
         cnt_d   = is_div_i ? DIV_CYCLES : MULT_CYCLES;
      end
   end
   assign busy_o = (state_q == MDU_BUSY);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: D-stage stall/flush control from Tuse/Tnew hazards and MDU occupancy
// Optional MDU stall tracking is enabled by defining PIPE_MDU_STALL_EN.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       Req,
   input  logic [4:0] D_rs_addr,
   input  logic [4:0] D_rt_addr,
   input  logic [1:0] D_Tuse_rs,
   input  logic [1:0] D_Tuse_rt,
   input  logic [4:0] E_A3,
   input  logic [4:0] M_A3,
   input  logic [1:0] E_Tnew,
   input  logic [1:0] M_Tnew,
   input  logic       D_is_md,
   input  logic       E_md_start,
   input  logic       E_md_is_div,
   output logic       stall,
   output logic       PC_EN,
   output logic       F_D_REG_EN,
   output logic       D_E_REG_clr,
   output logic       md_busy
);
   logic rs_stall, rt_stall, data_stall, md_stall;
   // an unused operand (TUSE_NONE) can never be outrun by a 2-bit Tnew, so the gate only makes intent explicit
   assign rs_stall = (D_rs_addr != 5'd0) && (D_Tuse_rs != TUSE_NONE) &&
                     ((E_A3 == D_rs_addr && E_Tnew > D_Tuse_rs) || (M_A3 == D_rs_addr && M_Tnew > D_Tuse_rs));
   assign rt_stall = (D_rt_addr != 5'd0) && (D_Tuse_rt != TUSE_NONE) &&
                     ((E_A3 == D_rt_addr && E_Tnew > D_Tuse_rt) || (M_A3 == D_rt_addr && M_Tnew > D_Tuse_rt));
   assign data_stall = rs_stall || rt_stall;
`ifdef PIPE_MDU_STALL_EN
   mdu_busy_cnt u_mdu (
      .clk      (clk),
      .reset    (reset),
      .start_i  (E_md_start),
      .is_div_i (E_md_is_div),
      .req_i    (Req),
      .busy_o   (md_busy)
   );
   assign md_stall = D_is_md && (E_md_start || md_busy);
`else
   logic unused_md;
   assign unused_md = ^{clk, reset, D_is_md, E_md_start, E_md_is_div};
   assign md_busy   = 1'b0;
   assign md_stall  = 1'b0;
`endif
   // a pending flush must let the PC load the handler, so it overrides any hold
   assign stall       = !Req && (data_stall || md_stall);
   assign PC_EN       = !stall;
   assign F_D_REG_EN  = !stall;
   assign D_E_REG_clr = Req || stall;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed and random checks of pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;
`ifdef PIPE_MDU_STALL_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif
   logic clk = 1'b0, reset, Req;
   logic [4:0] D_rs_addr, D_rt_addr, E_A3, M_A3;
   logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
   logic D_is_md, E_md_start, E_md_is_div;
   logic stall, PC_EN, F_D_REG_EN, D_E_REG_clr, md_busy;
   int errors = 0, checks = 0, rem = 0, busy_cnt;

   pipe_stall_ctrl dut (
      .clk(clk), .reset(reset), .Req(Req),
      .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
      .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
      .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
      .D_is_md(D_is_md), .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
      .stall(stall), .PC_EN(PC_EN), .F_D_REG_EN(F_D_REG_EN),
      .D_E_REG_clr(D_E_REG_clr), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit hz(input logic [4:0] a, input logic [1:0] tuse);
      int use_t = tuse;
      if (a == 0) return 1'b0;
      return (E_A3 == a && int'(E_Tnew) > use_t) || (M_A3 == a && int'(M_Tnew) > use_t);
   endfunction

   task automatic quiet();
      Req = 0; D_rs_addr = 0; D_rt_addr = 0; D_Tuse_rs = 3; D_Tuse_rt = 3;
      E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0;
      D_is_md = 0; E_md_start = 0; E_md_is_div = 0;
   endtask

   task automatic tick();
      bit busy, ds, ms, st;
      @(negedge clk);
      busy = MD_EN && rem > 0;
      ds = hz(D_rs_addr, D_Tuse_rs) || hz(D_rt_addr, D_Tuse_rt);
      ms = MD_EN && D_is_md && (E_md_start || busy);
      st = !Req && (ds || ms);
      chk("stall", stall, st);
      chk("pc_en", PC_EN, !st);
      chk("fd_en", F_D_REG_EN, !st);
      chk("de_clr", D_E_REG_clr, Req || st);
      chk("md_busy", md_busy, busy);
      @(posedge clk);
      if (reset) rem = 0;
      else if (rem > 0) rem--;
      else if (MD_EN && E_md_start && !Req) rem = E_md_is_div ? 10 : 5;
      #1;
   endtask

   initial begin
      quiet();
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      chk("rst_busy", md_busy, 0);
`ifdef PIPE_MDU_STALL_EN
      chk("rst_cnt", dut.u_mdu.cnt_q, 0);
`endif
      tick();
      E_A3 = 8; E_Tnew = 2; D_rs_addr = 8; D_Tuse_rs = 1;
      #1;
      chk("lu_stall", stall, 1);
      chk("lu_fden", F_D_REG_EN, 0);
      chk("lu_clr", D_E_REG_clr, 1);
      tick();
      E_A3 = 0; D_rs_addr = 0;
      #1;
      chk("r0_stall", stall, 0);
      tick();
      quiet();
      M_A3 = 9; M_Tnew = 1; D_rt_addr = 9; D_Tuse_rt = 0;
      #1;
      chk("m_rt_stall", stall, 1);
      Req = 1;
      #1;
      chk("req_stall", stall, 0);
      chk("req_pcen", PC_EN, 1);
      chk("req_clr", D_E_REG_clr, 1);
      tick();
      quiet();
      E_md_start = 1; E_md_is_div = 1; D_is_md = 1;
      busy_cnt = 0;
      tick();
      E_md_start = 0; E_md_is_div = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 10) busy_cnt += int'(md_busy);
         if (i == 10) chk("div_end", md_busy, 0);
         tick();
      end
      chk("div_len", 8'(busy_cnt), MD_EN ? 8'd10 : 8'd0);
      quiet();
      E_md_start = 1; Req = 1;
      #1;
      chk("sf_stall", stall, 0);
      chk("sf_clr", D_E_REG_clr, 1);
      tick();
      quiet();
      chk("sf_busy", md_busy, 0);
      tick();
      E_md_start = 1;
      tick();
      E_md_start = 0;
      tick();
      tick();
      reset = 1;
      tick();
      reset = 0;
      chk("mid_rst_busy", md_busy, 0);
`ifdef PIPE_MDU_STALL_EN
      chk("mid_rst_cnt", dut.u_mdu.cnt_q, 0);
`endif
      tick();
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 31) == 0);
         Req = ($urandom_range(0, 7) == 0);
         D_rs_addr = 5'($urandom_range(0, 3));
         D_rt_addr = 5'($urandom_range(0, 3));
         D_Tuse_rs = 2'($urandom);
         D_Tuse_rt = 2'($urandom);
         E_A3 = 5'($urandom_range(0, 3));
         M_A3 = 5'($urandom_range(0, 3));
         E_Tnew = 2'($urandom);
         M_Tnew = 2'($urandom);
         D_is_md = 1'($urandom);
         E_md_start = ($urandom_range(0, 5) == 0);
         E_md_is_div = 1'($urandom);
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
